treeval_loader: RTL and testbench
=================================

Name: treeval_loader

Overview:
- Host-side sequencer for the tree-evaluation engine.
- Accepts a node count and a stream of packed 32-bit node records over valid/ready, then drives the engine's sideband config/memory strobes one field per cycle.
- Once loading completes, pulses the engine reset to start evaluation and counts expectation-change pulses until the requested number of passes has elapsed.
- Captures the root reward/action and returns them on a valid/ready result port. Timeout and config errors are reported.

Parameters:
- W_ADDR, 10, node address width.
- W_REWARD, 10, signed reward width.
- W_ACTION, 3, action width.
- W_WEIGHT, 8, weight width.
- W_PASSES, 4, pass-count width.
- TIMEOUT_CYCLES, 65535, maximum cycles in RUN before error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_start  in  1  start request, sampled in IDLE/ERROR only
- cmd_nodes  in  W_ADDR  node count, sampled with cmd_start
- cmd_passes  in  W_PASSES  evaluation passes before capture; 0 treated as 1
- rec_valid  in  1  record valid
- rec_ready  out  1  record accept
- rec_data  in  32  record: [31:22] parent, [21:19] action, [18] strat, [17:8] reward, [7:0] weight
- tv_rst  out  1  engine reset
- tv_mem_weight, tv_mem_par, tv_mem_rew, tv_mem_act  out  1 each  field strobes
- tv_mem_addr  out  W_ADDR  node address
- tv_mem_data  out  W_ADDR  field data
- tv_conf_nodes  out  1  node-count strobe
- tv_conf_data  out  W_ADDR  node count
- tv_exp_change  in  1  engine pass-complete pulse
- tv_exp  in  W_REWARD  engine root reward (signed)
- tv_act  in  W_ACTION  engine root action
- res_valid  out  1  result valid
- res_ready  in  1  result accept
- res_exp  out  W_REWARD  captured reward
- res_act  out  W_ACTION  captured action
- busy  out  1  high in CONF..RESULT
- err  out  2  00 none, 01 bad node count, 10 timeout

Behaviour:
- Single clock, synchronous active-high reset.
- Reset behaviour:
  - FSM goes to IDLE.
  - All outputs are 0, except tv_rst, which is forced 1 combinationally while rst is high.
- States: IDLE, CONF, LOAD, WRITE, KICK, RUN, RESULT, ERROR.
- IDLE/ERROR on cmd_start:
  - err is cleared.
  - cmd_nodes < 2: go to ERROR with err=01, no strobes issued.
  - Otherwise: latch nodes and passes (max(cmd_passes,1)) and go to CONF.
  - cmd_start is ignored in all other states.
- CONF (1 cycle):
  - tv_conf_nodes=1, tv_conf_data=nodes.
  - addr counter cleared; go to LOAD.
- LOAD:
  - rec_ready=1; rec_ready is 0 in every other state.
  - On rec_valid & rec_ready: latch rec_data and go to WRITE. No strobes while waiting.
- WRITE (4 cycles, beat 0..3, exactly one strobe per cycle, tv_mem_addr=addr):
  - Beat 0: tv_mem_weight, data={2'b0,weight}.
  - Beat 1: tv_mem_par, data=parent.
  - Beat 2: tv_mem_rew, data=reward.
  - Beat 3: tv_mem_act, data={6'b0? no: data[3]=strat, data[2:0]=action, rest 0}.
  - addr==0 override: parent beat writes all-ones and weight beat writes 0, regardless of record contents.
  - After beat 3: addr==nodes-1 goes to KICK; otherwise addr++ and back to LOAD.
  - Minimum rate is 5 cycles per record.
  - Strobes and tv_mem_data are 0 outside WRITE.
- KICK (1 cycle):
  - tv_rst=1.
  - Pulse counter and timeout counter cleared; go to RUN.
- RUN:
  - Counts tv_exp_change pulses, ignoring any in the KICK cycle.
  - The first pulse after KICK precedes computation and is discarded.
  - On pulse number passes+1: sample tv_exp/tv_act that same cycle into res_exp/res_act, set res_valid, go to RESULT.
  - Timeout counter increments every RUN cycle; reaching TIMEOUT_CYCLES goes to ERROR with err=10 and res_valid=0.
- RESULT:
  - res_valid held, res_exp/res_act stable until res_ready.
  - On res_valid & res_ready: res_valid drops next cycle, go to IDLE.
  - res_exp/res_act retain their last value afterwards.
- ERROR: busy=0, err held until the next cmd_start.
- Reset mid-operation (any state): abort immediately to IDLE. Partially written engine memory is left as is; the next run rewrites every field.
- Simultaneous tv_exp_change and timeout on the same cycle: the capture wins.

Test Plan:
- 3-node tree, passes=1, root strat=1:
  - Records: node1 parent0 act0 rew100 wt128; node2 parent0 act1 rew-50 wt128.
  - Required: tv_conf_data=3, exactly 12 mem strobes in address order, root parent written 1023.
  - Result: res_exp=100, res_act=0, err=00.
- Same tree with root strat=0 -> res_exp=-50, res_act=1.
- Backpressure:
  - rec_valid deasserted 7 cycles between records -> no strobes during gaps and identical strobe sequence.
  - res_ready held low 10 cycles -> res_valid/res_exp stable, then IDLE one cycle after acceptance.
- cmd_nodes=1 -> ERROR, err=01, no tv_conf_nodes or mem strobes; a following valid cmd_start clears err and runs normally.
- Engine stub never pulses tv_exp_change, TIMEOUT_CYCLES=100 -> err=10 exactly 100 cycles after entering RUN, res_valid=0.
- rst asserted during beat 2 of node 1 -> next cycle all strobes 0, tv_rst=1 while rst high, FSM in IDLE; a new cmd_start reloads all nodes from addr 0.

Source files
------------

// File: rtl/treeval_loader.sv
// Host-side sequencer for the tree-evaluation engine: loads node records,
// kicks the engine, counts passes and returns the root reward/action.
module treeval_loader #(
  parameter int W_ADDR         = 10,
  parameter int W_REWARD       = 10,
  parameter int W_ACTION       = 3,
  parameter int W_WEIGHT       = 8,
  parameter int W_PASSES       = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_start,
  input  logic [W_ADDR-1:0]   cmd_nodes,
  input  logic [W_PASSES-1:0] cmd_passes,
  input  logic                rec_valid,
  output logic                rec_ready,
  input  logic [31:0]         rec_data,
  output logic                tv_rst,
  output logic                tv_mem_weight,
  output logic                tv_mem_par,
  output logic                tv_mem_rew,
  output logic                tv_mem_act,
  output logic [W_ADDR-1:0]   tv_mem_addr,
  output logic [W_ADDR-1:0]   tv_mem_data,
  output logic                tv_conf_nodes,
  output logic [W_ADDR-1:0]   tv_conf_data,
  input  logic                tv_exp_change,
  input  logic [W_REWARD-1:0] tv_exp,
  input  logic [W_ACTION-1:0] tv_act,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [W_REWARD-1:0] res_exp,
  output logic [W_ACTION-1:0] res_act,
  output logic                busy,
  output logic [1:0]          err
);

  localparam int W_TO = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W_TO-1:0] TO_LAST = W_TO'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CONF   = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_KICK   = 3'd4;
  localparam logic [2:0] S_RUN    = 3'd5;
  localparam logic [2:0] S_RESULT = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  logic [2:0]          state;
  logic [W_ADDR-1:0]   nodes;
  logic [W_PASSES-1:0] passes;
  logic [W_ADDR-1:0]   addr;
  logic [1:0]          beat;
  logic [31:0]         rec;
  logic [W_PASSES:0]   pcnt;
  logic [W_TO-1:0]     tcnt;
  logic                hit;
  logic                root;

  assign hit  = tv_exp_change && (pcnt == {1'b0, passes});
  assign root = (addr == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      nodes     <= '0;
      passes    <= '0;
      addr      <= '0;
      beat      <= '0;
      rec       <= '0;
      pcnt      <= '0;
      tcnt      <= '0;
      res_valid <= 1'b0;
      res_exp   <= '0;
      res_act   <= '0;
      err       <= 2'b00;
    end else begin
      unique case (state)
        S_IDLE, S_ERROR: begin
          if (cmd_start) begin
            if (cmd_nodes < W_ADDR'(2)) begin
              err   <= 2'b01;
              state <= S_ERROR;
            end else begin
              err    <= 2'b00;
              nodes  <= cmd_nodes;
              passes <= (cmd_passes == '0) ? W_PASSES'(1) : cmd_passes;
              state  <= S_CONF;
            end
          end
        end
        S_CONF: begin
          addr  <= '0;
          state <= S_LOAD;
        end
        S_LOAD: begin
          if (rec_valid) begin
            rec   <= rec_data;
            beat  <= 2'd0;
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          beat <= beat + 2'd1;
          if (beat == 2'd3) begin
            if (addr == nodes - W_ADDR'(1)) begin
              state <= S_KICK;
            end else begin
              addr  <= addr + W_ADDR'(1);
              state <= S_LOAD;
            end
          end
        end
        S_KICK: begin
          pcnt  <= '0;
          tcnt  <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          // first pulse after the kick is pre-computation, hence passes+1
          if (tv_exp_change) pcnt <= pcnt + 1'b1;
          tcnt <= tcnt + 1'b1;
          if (hit) begin
            res_exp   <= tv_exp;
            res_act   <= tv_act;
            res_valid <= 1'b1;
            state     <= S_RESULT;
          end else if (tcnt == TO_LAST) begin
            err   <= 2'b10;
            state <= S_ERROR;
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    tv_mem_weight = 1'b0;
    tv_mem_par    = 1'b0;
    tv_mem_rew    = 1'b0;
    tv_mem_act    = 1'b0;
    tv_mem_addr   = '0;
    tv_mem_data   = '0;
    tv_conf_nodes = 1'b0;
    tv_conf_data  = '0;
    if (!rst && state == S_CONF) begin
      tv_conf_nodes = 1'b1;
      tv_conf_data  = nodes;
    end
    if (!rst && state == S_WRITE) begin
      tv_mem_addr = addr;
      unique case (beat)
        2'd0: begin
          tv_mem_weight = 1'b1;
          tv_mem_data   = root ? '0 : W_ADDR'(rec[W_WEIGHT-1:0]);
        end
        2'd1: begin
          tv_mem_par  = 1'b1;
          tv_mem_data = root ? '1 : W_ADDR'(rec[22 +: W_ADDR]);
        end
        2'd2: begin
          tv_mem_rew  = 1'b1;
          tv_mem_data = W_ADDR'(rec[8 +: W_REWARD]);
        end
        2'd3: begin
          tv_mem_act  = 1'b1;
          tv_mem_data = W_ADDR'({rec[18], rec[19 +: W_ACTION]});
        end
      endcase
    end
  end

  assign rec_ready = !rst && (state == S_LOAD);
  assign tv_rst    = rst || (state == S_KICK);
  assign busy      = !rst && (state >= S_CONF) && (state <= S_RESULT);

endmodule

// File: tb/tb_treeval_loader.sv
// Randomized scoreboard bench for treeval_loader with a behavioural
// engine stub that evaluates the root from the memory it was sent.
module tb_treeval_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_start = 1'b0;
  logic [9:0]  cmd_nodes = '0;
  logic [3:0]  cmd_passes = '0;
  logic        rec_valid = 1'b0;
  logic        rec_ready;
  logic [31:0] rec_data = '0;
  logic        tv_rst;
  logic        tv_mem_weight, tv_mem_par, tv_mem_rew, tv_mem_act;
  logic [9:0]  tv_mem_addr, tv_mem_data;
  logic        tv_conf_nodes;
  logic [9:0]  tv_conf_data;
  logic        tv_exp_change = 1'b0;
  logic [9:0]  tv_exp = '0;
  logic [2:0]  tv_act = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [9:0]  res_exp;
  logic [2:0]  res_act;
  logic        busy;
  logic [1:0]  err;

  treeval_loader #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst),
    .cmd_start(cmd_start), .cmd_nodes(cmd_nodes), .cmd_passes(cmd_passes),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
    .tv_rst(tv_rst),
    .tv_mem_weight(tv_mem_weight), .tv_mem_par(tv_mem_par),
    .tv_mem_rew(tv_mem_rew), .tv_mem_act(tv_mem_act),
    .tv_mem_addr(tv_mem_addr), .tv_mem_data(tv_mem_data),
    .tv_conf_nodes(tv_conf_nodes), .tv_conf_data(tv_conf_data),
    .tv_exp_change(tv_exp_change), .tv_exp(tv_exp), .tv_act(tv_act),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_exp(res_exp), .res_act(res_act),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int addr; int data; } ev_t;
  typedef struct { int exp; int act; } res_t;
  ev_t  ev_q[$];
  res_t res_q[$];
  int compared = 0;
  int mismatched = 0;
  bit mute = 1'b0;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] req);
    compared++;
    if (got !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d required %0d", nm, $signed(got), $signed(req));
    end
  endtask

  // Engine stub: memory image plus pass pulses every 4 cycles after a kick
  logic [9:0] m_par[1024];
  logic [9:0] m_rew[1024];
  logic [9:0] m_act[1024];
  int m_nodes = 0;
  int st_t = 0;
  int st_j = 40;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      m_par[i] = '0;
      m_rew[i] = '0;
      m_act[i] = '0;
    end
  end

  function automatic void stub_eval(input int j, output int e, output int a);
    int best;
    bit first;
    bit strat;
    best = 0;
    a = 0;
    first = 1'b1;
    strat = m_act[0][3];
    for (int i = 1; i < m_nodes; i++) begin
      if (m_par[i] == 10'd0) begin
        int v;
        v = int'($signed(m_rew[i]));
        if (first || (strat ? v > best : v < best)) begin
          best = v;
          a = int'(m_act[i][2:0]);
          first = 1'b0;
        end
      end
    end
    e = best + 7 * (j - 2);
  endfunction

  always @(posedge clk) begin : stub
    int e, a;
    if (tv_conf_nodes) m_nodes <= int'(tv_conf_data);
    if (tv_mem_par) m_par[tv_mem_addr] <= tv_mem_data;
    if (tv_mem_rew) m_rew[tv_mem_addr] <= tv_mem_data;
    if (tv_mem_act) m_act[tv_mem_addr] <= tv_mem_data;
    if (tv_rst) begin
      st_t <= 0;
      st_j <= 0;
      tv_exp_change <= 1'b0;
    end else begin
      st_t <= st_t + 1;
      if (!mute && st_j < 40 && (st_t % 4) == 1) begin
        stub_eval(st_j + 1, e, a);
        tv_exp_change <= 1'b1;
        tv_exp <= 10'(e);
        tv_act <= 3'(a);
        st_j <= st_j + 1;
      end else begin
        tv_exp_change <= 1'b0;
      end
    end
  end

  // Strobe monitor
  always @(negedge clk) begin : smon
    int n, kind, addr, data;
    ev_t e;
    n = int'(tv_conf_nodes) + int'(tv_mem_weight) + int'(tv_mem_par)
      + int'(tv_mem_rew) + int'(tv_mem_act);
    if (n > 1) begin
      check("strobe_onehot", n, 1);
    end else if (n == 1) begin
      kind = tv_conf_nodes ? 0 : tv_mem_weight ? 1 : tv_mem_par ? 2 :
             tv_mem_rew ? 3 : 4;
      addr = tv_conf_nodes ? 0 : int'(tv_mem_addr);
      data = tv_conf_nodes ? int'(tv_conf_data) : int'(tv_mem_data);
      if (ev_q.size() == 0) begin
        check("strobe_unexpected_kind", kind, -1);
      end else begin
        e = ev_q.pop_front();
        check("strobe_kind", kind, e.kind);
        check("strobe_addr", addr, e.addr);
        check("strobe_data", data, e.data);
      end
    end
  end

  // Result monitor
  always @(negedge clk) begin : rmon
    res_t r;
    if (res_valid && res_ready) begin
      if (res_q.size() == 0) begin
        check("res_unexpected", 1, 0);
      end else begin
        r = res_q.pop_front();
        check("res_exp", int'($signed(res_exp)), r.exp);
        check("res_act", int'(res_act), r.act);
      end
    end
  end

  function automatic logic [31:0] mk(input logic [9:0] par, input logic [2:0] act,
                                     input logic strat, input logic [9:0] rew,
                                     input logic [7:0] wt);
    return {par, act, strat, rew, wt};
  endfunction

  function automatic res_t ref_eval(input logic [31:0] r[$], input int p);
    res_t o;
    int best, act;
    bit found;
    logic signed [9:0] w;
    best = 0;
    act = 0;
    found = 1'b0;
    for (int i = 1; i < r.size(); i++) begin
      if (r[i][31:22] == 10'd0) begin
        int v;
        v = int'($signed(r[i][17:8]));
        if (!found || (r[0][18] ? v > best : v < best)) begin
          best = v;
          act = int'(r[i][21:19]);
          found = 1'b1;
        end
      end
    end
    w = 10'(best + 7 * (((p == 0) ? 1 : p) - 1));
    o.exp = int'(w);
    o.act = act;
    return o;
  endfunction

  function automatic void push_conf(input int n);
    ev_t e;
    e.kind = 0; e.addr = 0; e.data = n;
    ev_q.push_back(e);
  endfunction

  function automatic void push_rec(input int i, input logic [31:0] d, input int beats);
    ev_t e;
    e.addr = i;
    e.kind = 1; e.data = (i == 0) ? 0 : int'(d[7:0]);
    if (beats > 0) ev_q.push_back(e);
    e.kind = 2; e.data = (i == 0) ? 1023 : int'(d[31:22]);
    if (beats > 1) ev_q.push_back(e);
    e.kind = 3; e.data = int'(d[17:8]);
    if (beats > 2) ev_q.push_back(e);
    e.kind = 4; e.data = int'({d[18], d[21:19]});
    if (beats > 3) ev_q.push_back(e);
  endfunction

  task automatic gen_tree(input int n, output logic [31:0] r[$]);
    r.delete();
    for (int i = 0; i < n; i++) begin
      logic [9:0] par;
      int rew;
      par = (i == 0) ? 10'($urandom) : 10'($urandom_range(0, i - 1));
      rew = int'($urandom_range(0, 100)) - 50;
      r.push_back(mk(par, 3'($urandom), 1'($urandom), 10'(rew), 8'($urandom)));
    end
  endtask

  task automatic start(input int n, input int p);
    @(posedge clk); #1;
    cmd_start = 1'b1;
    cmd_nodes = 10'(n);
    cmd_passes = 4'(p);
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  task automatic send_rec(input logic [31:0] d, input int gap);
    int t;
    t = 0;
    repeat (gap) @(posedge clk);
    #1;
    rec_valid = 1'b1;
    rec_data = d;
    @(negedge clk);
    while (!rec_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!rec_ready) check("rec_ready_timeout", 0, 1);
    @(posedge clk); #1;
    rec_valid = 1'b0;
    rec_data = '0;
  endtask

  task automatic run_tree(input logic [31:0] r[$], input int p,
                          input int gap, input bit stall);
    int t;
    logic [9:0] e0;
    push_conf(r.size());
    for (int i = 0; i < r.size(); i++) push_rec(i, r[i], 4);
    res_q.push_back(ref_eval(r, p));
    res_ready = !stall;
    start(r.size(), p);
    @(negedge clk);
    check("err_clear", err, 0);
    check("busy_conf", busy, 1);
    for (int i = 0; i < r.size(); i++) send_rec(r[i], gap);
    t = 0;
    while (!res_valid && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("res_valid_wait", res_valid, 1);
    if (stall && res_valid) begin
      e0 = res_exp;
      repeat (10) begin
        @(negedge clk);
        check("stall_valid", res_valid, 1);
        check("stall_exp", res_exp, e0);
      end
      @(posedge clk); #1;
      res_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    check("res_valid_drop", res_valid, 0);
    check("busy_idle", busy, 0);
    check("err_none", err, 0);
  endtask

  logic [31:0] tree[$];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int t;
    repeat (2) @(negedge clk);
    check("rst_tv_rst", tv_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_rec_ready", rec_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_err", err, 0);
    check("rst_conf", tv_conf_nodes, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("tv_rst_release", tv_rst, 0);

    // Directed 3-node tree, root max then min
    tree.delete();
    tree.push_back(mk(10'd555, 3'd5, 1'b1, 10'd7, 8'd99));
    tree.push_back(mk(10'd0, 3'd0, 1'b0, 10'd100, 8'd128));
    tree.push_back(mk(10'd0, 3'd1, 1'b0, -10'sd50, 8'd128));
    run_tree(tree, 1, 0, 1'b0);
    tree[0][18] = 1'b0;
    run_tree(tree, 1, 0, 1'b0);
    run_tree(tree, 1, 7, 1'b1);

    // Bad node count, then recovery
    start(1, 3);
    @(negedge clk);
    check("bad_nodes_err", err, 1);
    check("bad_nodes_busy", busy, 0);
    start(0, 0);
    @(negedge clk);
    check("bad_nodes0_err", err, 1);
    gen_tree(4, tree);
    run_tree(tree, 0, 1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      gen_tree(int'($urandom_range(2, 8)), tree);
      run_tree(tree, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
               1'($urandom));
    end

    // Silent engine -> timeout
    mute = 1'b1;
    gen_tree(2, tree);
    push_conf(2);
    for (int i = 0; i < 2; i++) push_rec(i, tree[i], 4);
    start(2, 1);
    for (int i = 0; i < 2; i++) send_rec(tree[i], 0);
    t = 0;
    @(negedge clk);
    while (!(tv_rst && !rst) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("kick_seen", tv_rst, 1);
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("to_early_err", err, 0);
    check("to_early_busy", busy, 1);
    @(posedge clk);
    @(negedge clk);
    check("to_err", err, 2);
    check("to_res_valid", res_valid, 0);
    check("to_busy", busy, 0);
    mute = 1'b0;

    // Reset during beat 2 of node 1
    gen_tree(3, tree);
    push_conf(3);
    push_rec(0, tree[0], 4);
    push_rec(1, tree[1], 2);
    start(3, 2);
    send_rec(tree[0], 0);
    send_rec(tree[1], 0);
    t = 0;
    @(negedge clk);
    while (!(tv_mem_par && tv_mem_addr == 10'd1) && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_strobes",
          {tv_mem_weight, tv_mem_par, tv_mem_rew, tv_mem_act, tv_conf_nodes}, 0);
    check("mid_rst_tv_rst", tv_rst, 1);
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tv_rst2", tv_rst, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_idle_busy", busy, 0);
    check("mid_rst_flush", ev_q.size(), 0);
    run_tree(tree, 2, 0, 1'b0);

    repeat (5) @(negedge clk);
    check("ev_q_empty", ev_q.size(), 0);
    check("res_q_empty", res_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
